// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared edge-mode constants and helpers for btn_event_sync
package btn_event_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Counter must hold 0..DEBOUNCE_CYCLES-1; sized for one extra value so D=1 still gets a bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic logic edge_enabled(input logic [1:0] mode, input logic new_level);
        if (new_level)
            return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        else
            return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, stability debounce, edge pulse and sticky pending
module debounce_channel
    import btn_event_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic [1:0] edge_mode,
    input  logic       clear,
    output logic       level,
    output logic       pulse,
    output logic       pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_pending;

    logic                   w_s;
    logic                   w_flip;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_level_next;
    logic                   w_pulse_next;
    logic                   w_pending_next;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A level change is accepted on the D-th consecutive disagreeing sample;
    // any agreeing sample restarts the count.
    always_comb begin
        w_cnt_next     = '0;
        w_flip         = 1'b0;
        if (w_s != r_level) begin
            if (r_cnt == CNT_LAST)
                w_flip = 1'b1;
            else
                w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_level_next   = w_flip ? w_s : r_level;
        w_pulse_next   = w_flip && edge_enabled(edge_mode, w_s);
        // A new event on the same edge as a clear must not be lost.
        w_pending_next = w_pulse_next || (r_pending && !clear);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], din};
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_pulse   <= w_pulse_next;
            r_pending <= w_pending_next;
        end
    end

    assign level   = r_level;
    assign pulse   = r_pulse;
    assign pending = r_pending;

endmodule

// File: rtl/btn_event_sync.sv
// rtl/btn_event_sync.sv - multi-channel button/strobe conditioner with sticky pending flags and irq
module btn_event_sync
    import btn_event_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [CHANNELS-1:0] w_pending;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .din      (din[g]),
            .edge_mode(edge_mode[2*g +: 2]),
            .clear    (clear[g]),
            .level    (level[g]),
            .pulse    (pulse[g]),
            .pending  (w_pending[g])
        );
    end

    assign pending = w_pending;
    assign irq     = |w_pending;

endmodule

// File: tb/tb_btn_event_sync.sv
// tb/tb_btn_event_sync.sv - randomized self-checking bench for btn_event_sync against a sample-window model
module tb_btn_event_sync;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int D  = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [CH-1:0] din       = '0;
    logic [2*CH-1:0] edge_mode = '0;
    logic [CH-1:0] clear     = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] pending;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    // hist[i] is the din vector sampled on post-reset edge i+1
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_level   = '0;
    logic [CH-1:0] m_pulse   = '0;
    logic [CH-1:0] m_pending = '0;

    btn_event_sync #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .edge_mode(edge_mode),
        .clear    (clear),
        .level    (level),
        .pulse    (pulse),
        .pending  (pending),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Synchronised value seen by the debouncer on post-reset edge j (1-based).
    function automatic logic s_at(input int c, input int j);
        logic [CH-1:0] v;
        if (j - S < 1) return 1'b0;
        v = hist[j - S - 1];
        return v[c];
    endfunction

    // Level flips on edge k when the last D synchronised samples all disagree with it.
    function automatic logic window_flip(input int c, input int k);
        if (k < D) return 1'b0;
        for (int j = k - D + 1; j <= k; j++)
            if (s_at(c, j) == m_level[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_model();
        check("level",   32'(level),   32'(m_level));
        check("pulse",   32'(pulse),   32'(m_pulse));
        check("pending", 32'(pending), 32'(m_pending));
        check("irq",     32'(irq),     32'(|m_pending));
    endtask

    task automatic step();
        logic [CH-1:0] nl, np, npend;
        logic flip;
        int   k;
        hist.push_back(din);
        k = hist.size();
        for (int c = 0; c < CH; c++) begin
            flip     = window_flip(c, k);
            nl[c]    = flip ? ~m_level[c] : m_level[c];
            np[c]    = flip && (nl[c] ? edge_mode[2*c] : edge_mode[2*c+1]);
            npend[c] = np[c] | (m_pending[c] & ~clear[c]);
        end
        @(posedge clk);
        #1;
        m_level   = nl;
        m_pulse   = np;
        m_pending = npend;
        check_model();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"},   32'(level),   32'd0);
        check({tag, "_pulse"},   32'(pulse),   32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_irq"},     32'(irq),     32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        check_zero("rst_async");
        hist.delete();
        m_level   = '0;
        m_pulse   = '0;
        m_pending = '0;
        repeat (cycles) @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        // Inputs high through reset; ch0 rise, ch1 fall, ch2 both, ch3 none.
        din       = 4'hF;
        edge_mode = 8'b00_11_10_01;
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        reset = 1'b1;
        repeat (5) step();
        check("rst_lvl5", 32'(level), 32'h0);
        step();
        check("rst_lvl6", 32'(level), 32'hF);
        check("rst_pls6", 32'(pulse), 32'h5);
        step();
        check("rst_pls7", 32'(pulse), 32'h0);
        check("rst_pend7", 32'(pending), 32'h5);
        check("rst_irq7", 32'(irq), 32'h1);
        clear = 4'hF;
        step();
        clear = 4'h0;

        // Falling edges on all channels, then clear.
        din = 4'h0;
        repeat (8) step();
        check("fall_pend", 32'(pending), 32'h6);
        clear = 4'hF;
        step();
        clear = 4'h0;

        // Short glitch on ch2 must not reach level.
        din = 4'b0100;
        repeat (3) step();
        din = 4'h0;
        repeat (8) step();
        check("glitch_lvl", 32'(level), 32'h0);
        check("glitch_pend", 32'(pending), 32'h0);

        // Clear on the same edge as a new pulse, then clear alone.
        din = 4'b0001;
        repeat (5) step();
        clear = 4'b0001;
        step();
        check("race_pulse", 32'(pulse[0]), 32'h1);
        check("race_pend", 32'(pending[0]), 32'h1);
        step();
        check("race_clr", 32'(pending[0]), 32'h0);
        check("race_irq", 32'(irq), 32'h0);
        clear = 4'h0;

        // Reset with ch3 counter part-way through.
        din = 4'b1001;
        repeat (4) step();
        do_reset(2);
        repeat (5) step();
        check("midrst_lvl5", 32'(level[3]), 32'h0);
        step();
        check("midrst_lvl6", 32'(level[3]), 32'h1);

        // Randomized phase: bursty toggles, random clears and modes, occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0)
                edge_mode = 8'($urandom);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
                clear[c] = ($urandom_range(0, 7) == 0);
            end
            if (cyc % 700 == 350)
                do_reset(int'($urandom_range(1, 3)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_event_sync.md
# btn_event_sync

Multi-channel input conditioner for the asynchronous push-buttons and sensor strobes on the watch.
- Per channel: synchronises the raw pin into `clk`, debounces it with a stability counter, and detects edges of a selectable polarity.
- Reports each qualified edge as a one-cycle pulse and as a sticky, write-1-to-clear pending bit.
- Sits between the top-level pins and the Avalon-facing control/IRQ register block.

## Interface
Parameters:
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change (≥1)
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- din  in  CHANNELS  raw asynchronous inputs
- edge_mode  in  2*CHANNELS  per channel, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
- clear  in  CHANNELS  write-1-to-clear for pending; single-cycle strobe from the register block
- level  out  CHANNELS  debounced level
- pulse  out  CHANNELS  one-cycle qualified-edge strobe
- pending  out  CHANNELS  sticky qualified-edge flags
- irq  out  1  OR of pending

## Operation
- Reset (reset=0, asynchronous): all synchroniser flops, counters, level, pulse and pending clear to 0; irq=0.
- Synchroniser: shift chain of SYNC_STAGES flops per channel; its output is `s`.
- Debounce, every edge, per channel:
  - if s==level: cnt←0
  - else if cnt==DEBOUNCE_CYCLES-1: level←s, cnt←0
  - else: cnt←cnt+1
- Any return of s to level before the terminal count discards the partial count; glitches shorter than DEBOUNCE_CYCLES synchronised cycles are never seen on level.
- Edge qualification uses the same clock edge that flips level:
  - rising = level flips 0→1; falling = level flips 1→0
  - pulse←1 for that single cycle iff the flip direction is enabled by edge_mode; otherwise pulse←0
  - edge_mode is sampled live at the flip edge
- Mode 00: level still tracks the input; pulse and pending are never set.
- Pending: set on any cycle pulse is set.
  - clear=1 on a channel without a same-edge set → pending←0
  - set and clear on the same edge → set wins, pending stays 1
- irq = |pending; combinational, so it has the same timing as pending.
- Channels are fully independent; simultaneous events on different channels are all captured.

## Timing
- Let S=SYNC_STAGES, D=DEBOUNCE_CYCLES. din changes and meets setup before edge 1:
  - s changes after edge S
  - level and pulse update after edge S+D
  - pulse deasserts after edge S+D+1
- Latency din→level/pulse = S+D cycles; pending follows pulse on the same edge.
- Maximum accepted toggle rate: one level change per D cycles.
- Reset mid-count: counter state is lost. After release, the full S+D latency applies again, measured against level=0.
- Inputs held at 1 through reset produce level rising at S+D cycles after the first post-release edge, and a pulse if the rising mode is enabled.

## Structure
- Shared package `btn_event_pkg`:
  - edge-mode constants EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH (2-bit)
  - helper function for CNT_W
- Sub-module `debounce_channel`: synchroniser, counter, level/pulse/pending for one channel, with ports clk, reset, din, edge_mode[1:0], clear, level, pulse, pending.
- Top instantiates CHANNELS copies in a generate loop and ORs pending into irq.

## Test plan
All scenarios use S=2, D=4, CHANNELS=4.
- Reset: din=4'hF held through reset → all outputs 0 during reset; after release, level=4'hF after the 6th edge; pulse only on channels with rise enabled.
- Clean rise, ch0, mode 01: din[0] 0→1 before edge 1 → level[0]=1 and pulse[0]=1 after edge 6; pulse[0]=0 after edge 7; pending[0]=1 and irq=1 persist.
- Glitch, ch2, mode 11: din[2] high for 3 cycles → level, pulse and pending all stay 0; internal counter returns to 0.
- Polarity, ch1:
  - mode 10: rise → level 1, no pulse; fall → pulse[1] one cycle, pending[1]=1
  - mode 00: both edges → level tracks, pending stays 0
- Clear race:
  - clear[0] asserted on the same edge as a new pulse[0] → pending[0] stays 1
  - clear[0] alone one cycle later → pending[0]=0 next edge; irq=0 if no other pending
- Reset mid-debounce: ch3 counter at 2, reset asserted → all state 0 immediately; din[3] still high after release → level[3] rises 6 edges after release.
